fifo_mem_reader: RTL and testbench
==================================

# fifo_mem_reader

Read-side controller for the 16-entry block FIFO memory. When the memory signals `full`, it walks `read_addr` from 0 to ADDR_SIZE-1 and presents each word on a valid/ready output stream. It then holds a clear request until the memory drops `full`, so the writer side can refill. It sits between the memory's `read_addr`/`data_out`/`full` ports and the downstream consumer.

## Interface
- DATA_WIDTH, 8, word width.
- ADDR_SIZE, 16, number of entries; power of two ≥ 2; AW = $clog2(ADDR_SIZE).
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mem_full  input  1  memory block full.
- mem_data  input  DATA_WIDTH  memory read data; valid one cycle after `read_addr` changes.
- read_addr  output  AW  memory read address.
- mem_clr  output  1  clear request to memory; level, held until `mem_full`=0.
- out_data  output  DATA_WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- flush  input  1  synchronous abort of the current burst.
- busy  output  1  high in any state other than IDLE.
- burst_cnt  output  16  completed bursts; present only with FIFO_RD_BURST_CNT_EN.

## Operation
- States: IDLE, FETCH, PRESENT, DONE.
- Reset values: state=IDLE, idx=0, read_addr=0, out_data=0, out_valid=0, mem_clr=0, busy=0, burst_cnt=0.
- `read_addr` always equals idx.
- IDLE: if mem_full=1, go to FETCH with idx=0.
- FETCH (one cycle): next edge captures mem_data into out_data, sets out_valid=1, goes to PRESENT.
- PRESENT: out_data and out_valid stay stable until the handshake (out_valid & out_ready).
  - On handshake with idx<ADDR_SIZE-1: idx+1, out_valid=0, go to FETCH.
  - On handshake with idx=ADDR_SIZE-1: out_valid=0, idx=0, go to DONE.
- DONE: mem_clr=1. When mem_full=0 is sampled, set mem_clr=0, burst_cnt+1 (wraps at 2^16), go to IDLE.
- flush=1 in FETCH or PRESENT: out_valid=0, idx=0, go to DONE. No handshake completes that cycle, even if out_ready=1. flush is ignored in IDLE and DONE.
- idx never exceeds ADDR_SIZE-1; no wrap beyond one burst.
- Reset mid-burst: all outputs return to reset values immediately; the partially read burst is abandoned and mem_clr is not issued.

## Timing
- mem_full sampled high at edge N in IDLE → out_valid=1 after edge N+1 with word 0.
- Handshake at edge M (not last word) → out_valid=0 after M, next word valid after M+2. Throughput is one word per 2 cycles with out_ready held high.
- Full burst with out_ready=1 throughout: 2·ADDR_SIZE cycles from first FETCH to DONE.
- Last handshake at M → mem_clr=1 after M. It drops on the edge that samples mem_full=0.
- mem_full still high when IDLE is re-entered starts a new burst. The writer must not reassert full before reading completes.

## Configuration
- FIFO_RD_BURST_CNT_EN defined: `burst_cnt` port and 16-bit counter present. The counter increments on every DONE→IDLE transition, flushed bursts included.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then mem_full=1, out_ready=1, memory loaded with 0x00..0x0F → words 0x00..0x0F appear in order, one per 2 cycles; mem_clr rises after the 16th handshake.
- out_ready=0 for 5 cycles while word 0x03 is presented → out_data holds 0x03 and out_valid stays 1; no address advance until ready returns.
- flush=1 in PRESENT at word 0x07 with out_ready=1 → no handshake that cycle; out_valid=0, DONE, mem_clr=1.
- In DONE, hold mem_full=1 for 4 cycles, then 0 → mem_clr stays 1 for those 4 cycles, drops on the edge sampling mem_full=0; busy=0 the next cycle.
- rst=1 asynchronously mid-burst at read_addr=9 → read_addr=0, out_valid=0, mem_clr=0, busy=0 without waiting for a clock edge.
- With FIFO_RD_BURST_CNT_EN: run 2 full bursts and 1 flushed burst → burst_cnt=3.

Source files
------------

// File: rtl/fifo_mem_reader.sv
// Read-side controller for the block FIFO memory: drains a full block over a valid/ready stream.
// Optional completed-burst counter enabled by defining FIFO_RD_BURST_CNT_EN.
module fifo_mem_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_SIZE  = 16,
   localparam int AW        = $clog2(ADDR_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_full,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic [AW-1:0]         read_addr,
   output logic                  mem_clr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  flush,
   output logic                  busy
`ifdef FIFO_RD_BURST_CNT_EN
   ,
   output logic [15:0]           burst_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(ADDR_SIZE - 1);

   state_t                  state_r, state_s;
   logic [AW-1:0]           idx_r, idx_s;
   logic [DATA_WIDTH-1:0]   data_r, data_s;
   logic                    valid_r, valid_s;
   logic                    clr_r;
   logic                    busy_r;

   // Next-state and datapath decisions; flush takes priority over any handshake.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      data_s  = data_r;
      valid_s = valid_r;
      case (state_r)
         IDLE: begin
            if (mem_full) begin
               state_s = FETCH;
               idx_s   = {AW{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         FETCH: begin
            if (flush) begin
               state_s = DONE;
               idx_s   = {AW{1'b0}};
               valid_s = 1'b0;
            end else begin
               state_s = PRESENT;
               data_s  = mem_data;
               valid_s = 1'b1;
            end
         end
         PRESENT: begin
            if (flush) begin
               state_s = DONE;
               idx_s   = {AW{1'b0}};
               valid_s = 1'b0;
            end else if (out_ready) begin
               valid_s = 1'b0;
               if (idx_r == LAST_IDX) begin
                  state_s = DONE;
                  idx_s   = {AW{1'b0}};
               end else begin
                  state_s = FETCH;
                  idx_s   = idx_r + AW'(1);
               end
            end else begin
               state_s = PRESENT;
            end
         end
         DONE: begin
            if (!mem_full) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
            idx_s   = {AW{1'b0}};
            valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers; mem_clr/busy are registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         idx_r   <= {AW{1'b0}};
         data_r  <= {DATA_WIDTH{1'b0}};
         valid_r <= 1'b0;
         clr_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         data_r  <= data_s;
         valid_r <= valid_s;
         clr_r   <= (state_s == DONE);
         busy_r  <= (state_s != IDLE);
      end
   end

`ifdef FIFO_RD_BURST_CNT_EN
   logic [15:0] cnt_r;

   // Completed-burst counter, counting every DONE to IDLE exit including flushed bursts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= 16'd0;
      end else if (state_r == DONE && state_s == IDLE) begin
         cnt_r <= cnt_r + 16'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign burst_cnt = cnt_r;
`endif

   assign read_addr = idx_r;
   assign out_data  = data_r;
   assign out_valid = valid_r;
   assign mem_clr   = clr_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_fifo_mem_reader.sv
// Scoreboard bench for fifo_mem_reader: each burst queues the block contents it must deliver,
// and a negedge monitor pops and compares on every stream handshake.
module tb_fifo_mem_reader;
   localparam int DW = 8;
   localparam int AS = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_full;
   logic [DW-1:0] mem_data;
   logic [AW-1:0] read_addr;
   logic          mem_clr;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          flush;
   logic          busy;
`ifdef FIFO_RD_BURST_CNT_EN
   logic [15:0]   burst_cnt;
`endif

   logic [DW-1:0] mem_arr [AS];
   logic [DW-1:0] exp_q [$];
   int            checks = 0;
   int            errors = 0;
   int            bursts = 0;

   fifo_mem_reader #(.DATA_WIDTH(DW), .ADDR_SIZE(AS)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_full  (mem_full),
      .mem_data  (mem_data),
      .read_addr (read_addr),
      .mem_clr   (mem_clr),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flush     (flush),
      .busy      (busy)
`ifdef FIFO_RD_BURST_CNT_EN
      ,
      .burst_cnt (burst_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory read data follows the address within the cycle.
   assign mem_data = mem_arr[read_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every handshake delivers the next queued word at the matching address;
   // a stalled word stays valid and unchanged.
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
         end
         if (out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_word: got %0h with nothing expected", out_data);
            end else begin
               check("word_addr", read_addr, AS - exp_q.size());
               check("word_data", out_data, exp_q.pop_front());
            end
         end
         prev_stall = out_valid && !out_ready && !flush;
         prev_data  = out_data;
      end
   end

   task automatic fill_mem(input bit rnd);
      for (int i = 0; i < AS; i++) mem_arr[i] = rnd ? DW'($urandom) : DW'(i);
   endtask

   // One burst from IDLE; flush_at/stall_at < 0 disable those events.
   task automatic burst(input int flush_at, input bit flush_fetch, input int stall_at,
                        input bit rnd, input int hold, input bit timed);
      int cyc = 0;
      bit done = 1'b0;
      bit flushed = 1'b0;
      bit stalled = 1'b0;
      bit in_stall;
      int stall_left = 0;
      mem_full = 1'b1;
      for (int i = 0; i < AS; i++) exp_q.push_back(mem_arr[i]);
      while (!done && cyc < 400) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         flush     = 1'b0;
         in_stall  = 1'b0;
         if (stall_left > 0) begin
            out_ready = 1'b0; in_stall = 1'b1; stall_left--;
         end else if (stall_at >= 0 && !stalled && out_valid && read_addr == AW'(stall_at)) begin
            out_ready = 1'b0; in_stall = 1'b1; stalled = 1'b1; stall_left = 4;
         end
         if (flush_at >= 0 && !flushed && busy && !mem_clr && read_addr == AW'(flush_at) &&
             (flush_fetch ? !out_valid : out_valid)) begin
            flush = 1'b1; out_ready = 1'b1; flushed = 1'b1;
         end
         @(negedge clk);
         cyc++;
         if (timed && cyc == 2) begin
            check("fetch_busy", busy, 1);
            check("fetch_valid", out_valid, 0);
         end
         if (timed && cyc == 3) begin
            check("first_valid", out_valid, 1);
            check("first_data", out_data, mem_arr[0]);
         end
         if (in_stall) begin
            check("stall_addr", read_addr, stall_at);
            check("stall_word", out_data, mem_arr[stall_at]);
         end
         done = mem_clr;
         @(posedge clk); #2;
      end
      flush = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL burst_timeout: mem_clr not seen after %0d cycles", cyc);
      end
      if (timed) check("burst_cycles", cyc, 34);
      check("done_busy", busy, 1);
      check("done_valid", out_valid, 0);
      if (flushed) begin
         check("flush_left", exp_q.size(), AS - flush_at);
         exp_q.delete();
      end else begin
         check("queue_drained", exp_q.size(), 0);
      end
      repeat (hold) begin
         @(negedge clk);
         check("clr_hold", mem_clr, 1);
         @(posedge clk); #2;
      end
      mem_full = 1'b0;
      @(negedge clk);
      check("clr_before_sample", mem_clr, 1);
      @(posedge clk); #2;
      bursts++;
      check("clr_dropped", mem_clr, 0);
      check("idle_busy", busy, 0);
`ifdef FIFO_RD_BURST_CNT_EN
      check("burst_cnt", burst_cnt, bursts);
`endif
   endtask

   // Asynchronous reset once the burst is presenting word 'at'.
   task automatic reset_mid(input int at);
      int n = 0;
      mem_full = 1'b1; out_ready = 1'b1; flush = 1'b0;
      for (int i = 0; i < AS; i++) exp_q.push_back(mem_arr[i]);
      while (!(out_valid && read_addr == AW'(at)) && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      check("reached_addr", read_addr, at);
      #1 rst = 1'b1;
      #1;
      check("arst_addr", read_addr, 0);
      check("arst_valid", out_valid, 0);
      check("arst_clr", mem_clr, 0);
      check("arst_busy", busy, 0);
      check("arst_data", out_data, 0);
      exp_q.delete();
      mem_full = 1'b0;
      bursts = 0;
      @(posedge clk); #2;
      rst = 1'b0;
`ifdef FIFO_RD_BURST_CNT_EN
      check("arst_cnt", burst_cnt, 0);
`endif
   endtask

   initial begin
      rst = 1'b1; mem_full = 1'b0; out_ready = 1'b0; flush = 1'b0;
      fill_mem(1'b0);
      @(negedge clk);
      check("rst_addr", read_addr, 0);
      check("rst_valid", out_valid, 0);
      check("rst_clr", mem_clr, 0);
      check("rst_busy", busy, 0);
      check("rst_data", out_data, 0);
      @(posedge clk); #2;
      rst = 1'b0;

      burst(-1, 1'b0, -1, 1'b0, 0, 1'b1);
      burst(-1, 1'b0,  3, 1'b0, 0, 1'b0);
      burst( 7, 1'b0, -1, 1'b0, 4, 1'b0);
      fill_mem(1'b1);
      burst(-1, 1'b0, -1, 1'b1, 1, 1'b0);
      fill_mem(1'b1);
      burst(int'($urandom_range(0, AS - 1)), 1'b1, -1, 1'b1, 2, 1'b0);
      fill_mem(1'b1);
      burst(-1, 1'b0, -1, 1'b0, 0, 1'b1);

      fill_mem(1'b1);
      reset_mid(9);
      fill_mem(1'b1);
      burst(-1, 1'b0, -1, 1'b1, 0, 1'b0);
      burst( 5, 1'b0, -1, 1'b0, 0, 1'b0);
      fill_mem(1'b1);
      burst(-1, 1'b0, -1, 1'b0, 1, 1'b1);
`ifdef FIFO_RD_BURST_CNT_EN
      check("final_burst_cnt", burst_cnt, 3);
`endif

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
